cam_capture_ctrl: RTL and testbench

Sits between the camera pixel front-end and the camera DMA writer. It gates whole frames into the DMA stream according to the APB camera control register outputs: one-shot trigger, continuous mode, config-done and DMA-init-done. It measures the incoming camera frame rate and produces the frames_per_second and debug status words read back over APB.

---
 rtl/cam_capture_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl
//   Gates whole camera frames into the DMA pixel stream and measures the
//   incoming frame rate.
//
//   Optional feature: define CAM_CAPTURE_PIXCNT_EN to count the pixels of each
//   captured frame into last_frame_pixels. Left undefined, that port is 0.
//
//   Ports:
//     clk, reset                 system clock, synchronous active-high reset
//     cam_confdone               sensor configured (level)
//     cam_dma_init_done          DMA ready (level)
//     trigger_capture_frame      rising edge requests one frame
//     continuous_capture_frame   capture every frame while high
//     in_frame_valid/in_valid/in_data   camera pixel stream
//     out_valid/out_data/out_sof/out_eof  pixel stream to DMA (1 cycle latency)
//     capture_busy               FSM in ARM or CAPTURE
//     frames_per_second          frames seen in the last full window
//     capture_status             {frame_count[15:0], 12'd0, trig_pending, state, enable}
//     last_frame_pixels          pixel count of last captured frame (optional)
module cam_capture_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int FPS_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cam_confdone,
    input  logic                  cam_dma_init_done,
    input  logic                  trigger_capture_frame,
    input  logic                  continuous_capture_frame,
    input  logic                  in_frame_valid,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  capture_busy,
    output logic [FPS_WIDTH-1:0]  frames_per_second,
    output logic [31:0]           capture_status,
    output logic [31:0]           last_frame_pixels
);

    localparam int WIN_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    trig_d_q, fv_d_q;
    logic                    trig_pending_q, trig_pending_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    sof_q, sof_d;
    logic                    sof_pend_q, sof_pend_d;
    logic                    eof_q, eof_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic [FPS_WIDTH-1:0]    fcnt_q, fcnt_d, fcnt_inc;
    logic [FPS_WIDTH-1:0]    fps_q, fps_d;

    logic enable, trig_rise, fv_rise, fv_fall, cap_start, gate, win_term;

    always_comb begin
        enable    = cam_confdone & cam_dma_init_done;
        trig_rise = trigger_capture_frame & ~trig_d_q;
        fv_rise   = in_frame_valid & ~fv_d_q;
        fv_fall   = ~in_frame_valid & fv_d_q;
        // A dropped enable in ARM wins over a coincident frame start.
        cap_start = (state_q == ARM) & fv_rise & enable;
        gate      = cap_start | ((state_q == CAPTURE) & in_frame_valid);
        valid_d   = in_valid & in_frame_valid & gate;
        eof_d     = (state_q == CAPTURE) & fv_fall;

        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && (trig_pending_q || continuous_capture_frame)) state_d = ARM;
            ARM:     if (!enable) state_d = IDLE;
                     else if (fv_rise) state_d = CAPTURE;
            CAPTURE: if (fv_fall) state_d = (continuous_capture_frame && enable) ? ARM : IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh trigger edge is kept even if it lands on the capture-start cycle.
        trig_pending_d = trig_pending_q;
        if (!enable)        trig_pending_d = 1'b0;
        else if (trig_rise) trig_pending_d = 1'b1;
        else if (cap_start) trig_pending_d = 1'b0;

        // sof rides on the first emitted pixel, which may come later than the
        // frame start when the line begins with blanking.
        sof_d      = valid_d & (cap_start | sof_pend_q);
        sof_pend_d = sof_pend_q;
        if (cap_start)             sof_pend_d = ~valid_d;
        else if (valid_d || eof_d) sof_pend_d = 1'b0;

        cnt_d = cnt_q + 16'(eof_d);

        win_term = (win_q == WIN_W'(CLK_FREQ_HZ - 1));
        win_d    = win_term ? '0 : win_q + WIN_W'(1);
        fcnt_inc = (fcnt_q == '1) ? fcnt_q : fcnt_q + FPS_WIDTH'(1);
        fps_d    = fps_q;
        fcnt_d   = fv_rise ? fcnt_inc : fcnt_q;
        if (win_term) begin
            // A frame starting on the terminal cycle belongs to the closing window.
            fps_d  = fcnt_d;
            fcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            trig_d_q       <= 1'b0;
            fv_d_q         <= 1'b0;
            trig_pending_q <= 1'b0;
            valid_q        <= 1'b0;
            data_q         <= '0;
            sof_q          <= 1'b0;
            sof_pend_q     <= 1'b0;
            eof_q          <= 1'b0;
            cnt_q          <= '0;
            win_q          <= '0;
            fcnt_q         <= '0;
            fps_q          <= '0;
        end else begin
            state_q        <= state_d;
            trig_d_q       <= trigger_capture_frame;
            fv_d_q         <= in_frame_valid;
            trig_pending_q <= trig_pending_d;
            valid_q        <= valid_d;
            data_q         <= in_data;
            sof_q          <= sof_d;
            sof_pend_q     <= sof_pend_d;
            eof_q          <= eof_d;
            cnt_q          <= cnt_d;
            win_q          <= win_d;
            fcnt_q         <= fcnt_d;
            fps_q          <= fps_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_data          = data_q;
    assign out_sof           = sof_q;
    assign out_eof           = eof_q;
    assign capture_busy      = (state_q == ARM) || (state_q == CAPTURE);
    assign frames_per_second = fps_q;
    assign capture_status    = {cnt_q, 12'd0, trig_pending_q, state_q, enable};

`ifdef CAM_CAPTURE_PIXCNT_EN
    logic [31:0] pix_q, pix_d, lfp_q, lfp_d;

    always_comb begin
        pix_d = pix_q;
        lfp_d = lfp_q;
        if (cap_start)                      pix_d = '0;
        else if (valid_q && pix_q != '1)    pix_d = pix_q + 32'd1;
        // By the out_eof cycle the last pixel has already been counted.
        if (eof_q)                          lfp_d = pix_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= '0;
            lfp_q <= '0;
        end else begin
            pix_q <= pix_d;
            lfp_q <= lfp_d;
        end
    end

    assign last_frame_pixels = lfp_q;
`else
    assign last_frame_pixels = '0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;
    localparam int DW = 16;
    localparam int CF = 1000;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cam_confdone, cam_dma_init_done;
    logic          trigger_capture_frame, continuous_capture_frame;
    logic          in_frame_valid, in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid, out_sof, out_eof, capture_busy;
    logic [DW-1:0] out_data;
    logic [FW-1:0] frames_per_second;
    logic [31:0]   capture_status, last_frame_pixels;

    always #5 clk = ~clk;

    cam_capture_ctrl #(.DATA_WIDTH(DW), .CLK_FREQ_HZ(CF), .FPS_WIDTH(FW)) dut (
        .clk(clk), .reset(reset),
        .cam_confdone(cam_confdone), .cam_dma_init_done(cam_dma_init_done),
        .trigger_capture_frame(trigger_capture_frame),
        .continuous_capture_frame(continuous_capture_frame),
        .in_frame_valid(in_frame_valid), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .capture_busy(capture_busy), .frames_per_second(frames_per_second),
        .capture_status(capture_status), .last_frame_pixels(last_frame_pixels)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
    } px_t;

    px_t         px_q[$];   // expected pixels in order
    int          eof_q[$];  // expected pixel count per captured frame
    int          rx_n = 0;
    bit          eof_seen = 0;
    int          lfp_exp = 0;
    px_t         e_px;
    int          e_n;
    int          tcyc = 0;
    logic [DW-1:0] seed = 16'h1234;

    // window-aligned cycle index, restarts with reset like the measurement window
    always @(posedge clk) tcyc <= reset ? 0 : tcyc + 1;

    always @(negedge clk) begin
        if (reset) rx_n = 0;
        if (eof_seen) begin
            chk("last_frame_pixels", last_frame_pixels, lfp_exp);
            eof_seen = 0;
        end
        if (out_sof && !out_valid) chk("sof_without_valid", 1, 0);
        if (out_valid) begin
            if (px_q.size() == 0) chk("unexpected_pixel", 1, 0);
            else begin
                e_px = px_q.pop_front();
                chk("px_data", out_data, e_px.data);
                chk("px_sof", out_sof, e_px.sof);
            end
            rx_n++;
        end
        if (out_eof) begin
            if (eof_q.size() == 0) chk("unexpected_eof", 1, 0);
            else begin
                e_n = eof_q.pop_front();
                chk("eof_npix", rx_n, e_n);
`ifdef CAM_CAPTURE_PIXCNT_EN
                lfp_exp = e_n;
`else
                lfp_exp = 0;
`endif
                eof_seen = 1;
            end
            rx_n = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One camera frame: a stray in_valid outside the frame, then npix pixels in
    // lines of 4 with 2 blanking cycles. Optional trigger/continuous edits mid-frame.
    task automatic frame(input int npix, input bit cap, input int trig_at, input int cont_clr_at);
        px_t p;
        in_frame_valid = 1'b0; in_valid = 1'b1; in_data = 16'hdead;
        step();
        in_valid = 1'b0; in_frame_valid = 1'b1;
        for (int i = 0; i < npix; i++) begin
            if (i == trig_at)     trigger_capture_frame = 1'b1;
            if (i == cont_clr_at) continuous_capture_frame = 1'b0;
            in_valid = 1'b1; in_data = seed;
            if (cap) begin
                p.data = seed; p.sof = (i == 0);
                px_q.push_back(p);
            end
            seed = seed + 16'h1357;
            step();
            if (i % 4 == 3) begin
                in_valid = 1'b0;
                repeat (2) step();
            end
        end
        if (npix == 0) repeat (3) step();
        in_valid = 1'b0; in_frame_valid = 1'b0;
        if (cap) eof_q.push_back(npix);
        repeat (4) step();
    endtask

    task automatic trig_pulse();
        trigger_capture_frame = 1'b0; step();
        trigger_capture_frame = 1'b1; step(); step();
    endtask

    initial begin
        reset = 1'b1;
        cam_confdone = 0; cam_dma_init_done = 0;
        trigger_capture_frame = 0; continuous_capture_frame = 0;
        in_frame_valid = 0; in_valid = 0; in_data = '0;
        repeat (3) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_eof", out_eof, 0);
        chk("rst_busy", capture_busy, 0);
        chk("rst_fps", frames_per_second, 0);
        chk("rst_status", capture_status, 0);
        chk("rst_lfp", last_frame_pixels, 0);
        reset = 1'b0;
        step();

        // one-shot trigger: first frame after it captured, second not
        cam_confdone = 1; cam_dma_init_done = 1;
        trig_pulse();
        chk("arm_busy", capture_busy, 1);
        chk("arm_status", capture_status, 32'h0000_000B);
        frame(16, 1, -1, -1);
        frame(16, 0, -1, -1);
        chk("t1_status", capture_status, 32'h0001_0001);

        // trigger mid-frame: remainder dropped, next full frame captured
        trigger_capture_frame = 0; step();
        frame(16, 0, 5, -1);
        frame(16, 1, -1, -1);
        chk("t2_status", capture_status, 32'h0002_0001);

        // frame with no pixels still yields eof, no sof
        trig_pulse();
        frame(0, 1, -1, -1);
        chk("t_zero_status", capture_status, 32'h0003_0001);

        // continuous across 3 frames, cleared during the 3rd
        continuous_capture_frame = 1; step();
        frame(16, 1, -1, -1);
        frame(12, 1, -1, -1);
        frame(16, 1, -1, 8);
        frame(16, 0, -1, -1);
        chk("t3_status", capture_status, 32'h0006_0001);
        chk("t3_busy", capture_busy, 0);

        // DMA not ready: trigger ignored and not remembered
        cam_dma_init_done = 0;
        trig_pulse();
        chk("noen_status", capture_status, 32'h0006_0000);
        frame(16, 0, -1, -1);
        cam_dma_init_done = 1; step(); step();
        chk("noen_status2", capture_status, 32'h0006_0001);
        chk("noen_busy", capture_busy, 0);
        frame(16, 0, -1, -1);

        // reset mid-capture: no eof, outputs cleared
        trig_pulse();
        in_frame_valid = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_data = seed;
            e_px.data = seed; e_px.sof = (i == 0);
            px_q.push_back(e_px);
            seed = seed + 16'h1357;
            step();
        end
        reset = 1; in_valid = 0; in_frame_valid = 0;
        step();
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_sof", out_sof, 0);
        chk("abort_eof", out_eof, 0);
        chk("abort_busy", capture_busy, 0);
        chk("abort_fps", frames_per_second, 0);
        chk("abort_status", capture_status[31:1], 0);
        #1;
        reset = 0;
        cam_confdone = 0;

        // FPS: a frame every 200 cycles, one starting on the terminal cycle
        for (int k = 1; k <= 10; k++) begin
            while (tcyc != 200 * k - 1) step();
            in_frame_valid = 1;
            step();
            if (k == 3)  chk("fps_before", frames_per_second, 0);
            if (k == 5)  chk("fps_win1", frames_per_second, 5);
            if (k == 10) chk("fps_win2", frames_per_second, 5);
            repeat (30) step();
            in_frame_valid = 0;
        end
        while (tcyc != 2500) step();
        chk("fps_hold", frames_per_second, 5);
        while (tcyc != 3000) step();
        chk("fps_win3", frames_per_second, 0);

        // long frame for the pixel counter
        cam_confdone = 1;
        trig_pulse();
        frame(640, 1, -1, -1);
        chk("big_status", capture_status, 32'h0001_0001);

        chk("px_q_empty", px_q.size(), 0);
        chk("eof_q_empty", eof_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
